// File: rtl/bcd_disp_pkg.sv
// Shared constants for the BCD display scanner: active-high seven-segment
// patterns in {g,f,e,d,c,b,a} order and the scan FSM state encoding.
package bcd_disp_pkg;

  localparam logic [6:0] SEG7_0     = 7'h3F;
  localparam logic [6:0] SEG7_1     = 7'h06;
  localparam logic [6:0] SEG7_2     = 7'h5B;
  localparam logic [6:0] SEG7_3     = 7'h4F;
  localparam logic [6:0] SEG7_4     = 7'h66;
  localparam logic [6:0] SEG7_5     = 7'h6D;
  localparam logic [6:0] SEG7_6     = 7'h7D;
  localparam logic [6:0] SEG7_7     = 7'h07;
  localparam logic [6:0] SEG7_8     = 7'h7F;
  localparam logic [6:0] SEG7_9     = 7'h6F;
  localparam logic [6:0] SEG7_DASH  = 7'h40;
  localparam logic [6:0] SEG7_BLANK = 7'h00;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_BLANK = 2'd1;
  localparam logic [1:0] ST_DRIVE = 2'd2;

endpackage

// File: rtl/bcd_display_scanner_if.sv
// Data/control bundle between the BCD counter chain and the display scanner.
interface bcd_display_scanner_if #(
  parameter int NUM_DIGITS = 4
);
  logic                    Enable;
  logic                    Load;
  logic [4*NUM_DIGITS-1:0] Bcd_in;
  logic [NUM_DIGITS-1:0]   Dp_in;
  logic [6:0]              Seg;
  logic                    Dp;
  logic [NUM_DIGITS-1:0]   Anode;
  logic                    Digit_err;

  modport master (
    output Enable, Load, Bcd_in, Dp_in,
    input  Seg, Dp, Anode, Digit_err
  );

  modport slave (
    input  Enable, Load, Bcd_in, Dp_in,
    output Seg, Dp, Anode, Digit_err
  );
endinterface

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-high seven-segment pattern; codes
// above 9 render as a dash so a bad digit is visible on the glass.
module bcd_to_seg7
  import bcd_disp_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [6:0] seg
);

  // Nibble lookup
  always_comb begin
    case (bcd)
      4'd0:    seg = SEG7_0;
      4'd1:    seg = SEG7_1;
      4'd2:    seg = SEG7_2;
      4'd3:    seg = SEG7_3;
      4'd4:    seg = SEG7_4;
      4'd5:    seg = SEG7_5;
      4'd6:    seg = SEG7_6;
      4'd7:    seg = SEG7_7;
      4'd8:    seg = SEG7_8;
      4'd9:    seg = SEG7_9;
      default: seg = SEG7_DASH;
    endcase
  end

endmodule

// File: rtl/bcd_display_scanner.sv
// Time-multiplexed common-anode seven-segment scanner.
//
//   state | meaning
//   IDLE  | display dark, waiting for Enable
//   BLANK | one guard cycle, all anodes off; pattern for the digit is captured
//   DRIVE | digit shown from the hold register for REFRESH_DIV-1 cycles
//
// Outputs are registered from next-state values so they switch on the same
// edge as the state. The hold register decouples the shown digit from the
// shadow registers, so a Load mid-slot never tears the current digit.
module bcd_display_scanner
  import bcd_disp_pkg::*;
#(
  parameter int NUM_DIGITS     = 4,
  parameter int REFRESH_DIV    = 50000,
  parameter int SEG_ACTIVE_LOW = 1,
  parameter int BLANK_LEADING  = 1
) (
  input logic                  Clk,
  input logic                  Clear,
  bcd_display_scanner_if.slave bus
);

  localparam int IW = $clog2(NUM_DIGITS);
  localparam int PW = $clog2(REFRESH_DIV);
  localparam logic [PW-1:0] PRESC_TC  = PW'(REFRESH_DIV - 2);
  localparam logic [IW-1:0] IDX_LAST  = IW'(NUM_DIGITS - 1);
  localparam logic [6:0]    SEG_OFF   = (SEG_ACTIVE_LOW != 0) ? 7'h7F : 7'h00;
  localparam logic          DP_OFF    = (SEG_ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]              state, state_nx;
  logic [IW-1:0]           idx, idx_nx;
  logic [PW-1:0]           presc, presc_nx;
  logic [4*NUM_DIGITS-1:0] shadow_bcd;
  logic [NUM_DIGITS-1:0]   shadow_dp;
  logic [6:0]              hold_seg, hold_seg_nx;
  logic                    hold_dp, hold_dp_nx;
  logic                    hold_blank, hold_blank_nx;
  logic                    latch;

  logic [3:0]              digit [NUM_DIGITS];
  logic [3:0]              cur_digit;
  logic [6:0]              cur_seg;
  logic                    upper_zero;
  logic                    cur_blank;
  logic                    invalid_in;

  logic [6:0]              seg_nx;
  logic                    dp_nx;
  logic [NUM_DIGITS-1:0]   anode_nx;

  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_digit
    assign digit[g] = shadow_bcd[4*g +: 4];
  end

  assign cur_digit = digit[idx];

  bcd_to_seg7 u_dec (
    .bcd (cur_digit),
    .seg (cur_seg)
  );

  // Leading-zero test: current digit and every digit above it are zero
  always_comb begin
    upper_zero = 1'b1;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (j >= int'(idx) && digit[j] != 4'd0) upper_zero = 1'b0;
    end
  end

  // Digit 0 is never blanked; a set decimal point keeps the digit visible
  assign cur_blank = (BLANK_LEADING != 0) && (idx != '0) && upper_zero && !shadow_dp[idx];

  // Any out-of-range nibble on the incoming word
  always_comb begin
    invalid_in = 1'b0;
    for (int j = 0; j < NUM_DIGITS; j++) begin
      if (bus.Bcd_in[4*j +: 4] > 4'd9) invalid_in = 1'b1;
    end
  end

  // Scan sequencing: next state, digit index and slot prescaler
  always_comb begin
    state_nx = state;
    idx_nx   = idx;
    presc_nx = presc;
    latch    = 1'b0;
    case (state)
      ST_IDLE: begin
        if (bus.Enable) begin
          state_nx = ST_BLANK;
          idx_nx   = '0;
          presc_nx = '0;
        end
      end
      ST_BLANK: begin
        if (!bus.Enable) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
          presc_nx = '0;
        end else begin
          state_nx = ST_DRIVE;
          presc_nx = '0;
          latch    = 1'b1;
        end
      end
      ST_DRIVE: begin
        if (!bus.Enable) begin
          state_nx = ST_IDLE;
          idx_nx   = '0;
          presc_nx = '0;
        end else if (presc == PRESC_TC) begin
          state_nx = ST_BLANK;
          presc_nx = '0;
          idx_nx   = (idx == IDX_LAST) ? '0 : idx + 1'b1;
        end else begin
          presc_nx = presc + 1'b1;
        end
      end
      default: begin
        state_nx = ST_IDLE;
        idx_nx   = '0;
        presc_nx = '0;
      end
    endcase
  end

  // Hold register capture and polarity-adjusted output next values
  always_comb begin
    hold_seg_nx   = hold_seg;
    hold_dp_nx    = hold_dp;
    hold_blank_nx = hold_blank;
    if (latch) begin
      hold_seg_nx   = cur_blank ? SEG7_BLANK : cur_seg;
      hold_dp_nx    = shadow_dp[idx] && !cur_blank;
      hold_blank_nx = cur_blank;
    end

    seg_nx   = SEG_OFF;
    dp_nx    = DP_OFF;
    anode_nx = '1;
    if (state_nx == ST_DRIVE && !hold_blank_nx) begin
      seg_nx   = (SEG_ACTIVE_LOW != 0) ? ~hold_seg_nx : hold_seg_nx;
      dp_nx    = (SEG_ACTIVE_LOW != 0) ? ~hold_dp_nx : hold_dp_nx;
      anode_nx = ~(NUM_DIGITS'(1) << idx_nx);
    end
  end

  // State, shadow, hold and output registers with synchronous clear
  always_ff @(posedge Clk) begin
    if (Clear) begin
      state         <= ST_IDLE;
      idx           <= '0;
      presc         <= '0;
      shadow_bcd    <= '0;
      shadow_dp     <= '0;
      hold_seg      <= SEG7_BLANK;
      hold_dp       <= 1'b0;
      hold_blank    <= 1'b1;
      bus.Seg       <= SEG_OFF;
      bus.Dp        <= DP_OFF;
      bus.Anode     <= '1;
      bus.Digit_err <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      presc      <= presc_nx;
      hold_seg   <= hold_seg_nx;
      hold_dp    <= hold_dp_nx;
      hold_blank <= hold_blank_nx;
      bus.Seg    <= seg_nx;
      bus.Dp     <= dp_nx;
      bus.Anode  <= anode_nx;
      if (bus.Load) begin
        shadow_bcd <= bus.Bcd_in;
        shadow_dp  <= bus.Dp_in;
        if (invalid_in) bus.Digit_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_bcd_display_scanner.sv
// Self-checking bench for bcd_display_scanner (4 digits, 4-cycle slots,
// active-low segments). The reference model tracks cycles since Enable and
// derives slot/digit position arithmetically from that count.
module tb_bcd_display_scanner;

  localparam int N = 4;
  localparam int R = 4;

  logic Clk = 1'b0;
  logic Clear;

  bcd_display_scanner_if #(.NUM_DIGITS(N)) bus ();

  bcd_display_scanner #(
    .NUM_DIGITS     (N),
    .REFRESH_DIV    (R),
    .SEG_ACTIVE_LOW (1),
    .BLANK_LEADING  (1)
  ) dut (
    .Clk   (Clk),
    .Clear (Clear),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int n_asserts = 0;
  int n_fail    = 0;

  // reference state
  int          k = -1;
  logic [15:0] m_bcd = '0;
  logic [3:0]  m_dp = '0;
  logic [15:0] snap_bcd = '0;
  logic [3:0]  snap_dp = '0;
  logic        m_err = 1'b0;

  logic [6:0] lut [10] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19,
                           7'h12, 7'h02, 7'h78, 7'h00, 7'h10};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_asserts++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d)", tag, obs, exp, k);
    end
  endtask

  task automatic cyc(input logic en, input logic ld, input logic [15:0] b,
                     input logic [3:0] d, input logic clr);
    int pos, dg;
    logic [3:0] ea;
    logic [6:0] es;
    logic       ed;
    logic [3:0] nib;
    bus.Enable = en;
    bus.Load   = ld;
    bus.Bcd_in = b;
    bus.Dp_in  = d;
    Clear      = clr;
    @(posedge Clk);
    if (clr) begin
      k = -1; m_bcd = '0; m_dp = '0; m_err = 1'b0;
    end else begin
      k = en ? k + 1 : -1;
      if (k >= 0 && k % R == 1) begin
        snap_bcd = m_bcd;
        snap_dp  = m_dp;
      end
      if (ld) begin
        m_bcd = b;
        m_dp  = d;
        for (int i = 0; i < N; i++) begin
          nib = 4'((b >> (4*i)) & 16'hF);
          if (nib > 4'd9) m_err = 1'b1;
        end
      end
    end
    ea = 4'hF; es = 7'h7F; ed = 1'b1;
    if (k >= 0 && k % R != 0) begin
      pos = k % R;
      dg  = (k / R) % N;
      if (!(dg > 0 && (snap_bcd >> (4*dg)) == 16'd0 && !snap_dp[dg])) begin
        nib = 4'((snap_bcd >> (4*dg)) & 16'hF);
        ea  = ~(4'd1 << dg);
        es  = (nib > 4'd9) ? 7'h3F : lut[nib];
        ed  = ~snap_dp[dg];
      end
    end
    #1;
    chk("anode", 32'(bus.Anode), 32'(ea));
    chk("seg", 32'(bus.Seg), 32'(es));
    chk("dp", 32'(bus.Dp), 32'(ed));
    chk("digit_err", 32'(bus.Digit_err), 32'(m_err));
  endtask

  task automatic run(input int n, input logic en);
    for (int i = 0; i < n; i++) cyc(en, 1'b0, 16'h0, 4'h0, 1'b0);
  endtask

  function automatic logic [15:0] rand_bcd();
    logic [15:0] v;
    int sig;
    v = '0;
    sig = $urandom_range(1, N);
    for (int i = 0; i < sig; i++) begin
      if ($urandom_range(0, 9) == 0) v[4*i +: 4] = 4'($urandom_range(10, 15));
      else v[4*i +: 4] = 4'($urandom_range(0, 9));
    end
    return v;
  endfunction

  initial begin
    bit found;
    logic [15:0] rb;

    // reset with arbitrary inputs
    cyc(1'b1, 1'b1, 16'hFFFF, 4'hF, 1'b1);
    cyc(1'b1, 1'b1, 16'hABCD, 4'h5, 1'b1);
    chk("reset_anode", 32'(bus.Anode), 32'hF);
    chk("reset_seg", 32'(bus.Seg), 32'h7F);

    // basic scan
    cyc(1'b0, 1'b1, 16'h1234, 4'h0, 1'b0);
    run(2 * N * R, 1'b1);

    // leading zeros, then DP un-blanking digit 2
    cyc(1'b0, 1'b1, 16'h0070, 4'b0000, 1'b0);
    run(N * R + 2, 1'b1);
    cyc(1'b0, 1'b1, 16'h0070, 4'b0100, 1'b0);
    run(N * R + 2, 1'b1);

    // invalid code is sticky
    cyc(1'b1, 1'b1, 16'h00A5, 4'h0, 1'b0);
    run(N * R, 1'b1);
    cyc(1'b1, 1'b1, 16'h0000, 4'h0, 1'b0);
    run(N * R, 1'b1);
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b1);

    // tear-free update while digit 2 is in DRIVE
    cyc(1'b1, 1'b1, 16'h1234, 4'h0, 1'b0);
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (k >= 0 && (k / R) % N == 2 && k % R == 1) found = 1'b1;
      else cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    end
    chk("wait_digit2_drive", 32'(found), 32'd1);
    cyc(1'b1, 1'b1, 16'h9999, 4'h0, 1'b0);
    run(2 * R, 1'b1);

    // Load coincident with terminal count
    found = 1'b0;
    for (int i = 0; i < 40 && !found; i++) begin
      if (k >= 0 && k % R == R - 1) found = 1'b1;
      else cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b0);
    end
    chk("wait_terminal_count", 32'(found), 32'd1);
    cyc(1'b1, 1'b1, 16'h5678, 4'h2, 1'b0);
    run(R + 1, 1'b1);

    // Enable drop and Clear mid-DRIVE
    cyc(1'b0, 1'b0, 16'h0, 4'h0, 1'b0);
    chk("disable_dark", 32'(bus.Anode), 32'hF);
    run(2, 1'b0);
    run(R + 2, 1'b1);
    cyc(1'b1, 1'b0, 16'h0, 4'h0, 1'b1);
    chk("clear_dark", 32'(bus.Anode), 32'hF);
    run(R * N, 1'b1);

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rb = rand_bcd();
      cyc(($urandom_range(0, 39) != 0),
          ($urandom_range(0, 5) == 0),
          rb,
          4'($urandom_range(0, 15)),
          ($urandom_range(0, 149) == 0));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end

endmodule
